// File: rtl/mul_div_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider, one bit per clock.
// Latency: start sampled in cycle 0 -> done_o in cycle W+2; divide-by-zero/overflow short-cut -> done_o in cycle 1.
// Backpressure: stall_o holds the core while the unit works; start_i is only accepted in IDLE and is ignored in DONE.
//
// Ports:
//   clk, reset              core clock (rising edge), asynchronous active-high reset
//   start_i, funct3_i       M-extension instruction present in decode and its funct3 opcode
//   rs1_data_i, rs2_data_i  operand A (multiplicand/dividend), operand B (multiplier/divisor)
//   flush_i                 synchronous abort, returns to IDLE from any state
//   stall_o, busy_o         hold PC / suppress writeback; unit occupied (CALC or FIXUP)
//   done_o, result_o        one-cycle result-valid pulse; registered result
module mul_div_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W = DATA_WIDTH;

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(W - 1);
    localparam logic [W-1:0]         MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Datapath state. acc_q is shared by both engines:
    //   multiply: {partial product high, multiplier being shifted out}
    //   divide:   {partial remainder, dividend shifting out / quotient shifting in}
    logic [CNT_WIDTH-1:0] cnt_q,     cnt_d;
    logic [2*W-1:0]       acc_q,     acc_d;
    logic [W-1:0]         opb_q,     opb_d;     // multiplicand or divisor magnitude
    logic [2:0]           op_q,      op_d;
    logic                 neg_q,     neg_d;     // product / quotient sign
    logic                 rem_neg_q, rem_neg_d; // remainder sign (dividend sign)
    logic [W-1:0]         result_q,  result_d;

    // ------------------------------------------------------------------
    // Operand decode (IDLE-cycle inputs)
    // ------------------------------------------------------------------
    logic         accept;
    logic         sign_a_en, sign_b_en;
    logic         sign_a, sign_b;
    logic [W-1:0] abs_a, abs_b;
    logic         div_by_zero, div_ovf, special;
    logic [W-1:0] special_res;

    always_comb begin
        accept    = start_i & ~flush_i;
        sign_a_en = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
                    (funct3_i == F_DIV)  || (funct3_i == F_REM);
        sign_b_en = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
        sign_a    = sign_a_en & rs1_data_i[W-1];
        sign_b    = sign_b_en & rs2_data_i[W-1];
        // The most negative value maps to 2^(W-1), which is still a valid unsigned magnitude.
        abs_a     = sign_a ? (~rs1_data_i + 1'b1) : rs1_data_i;
        abs_b     = sign_b ? (~rs2_data_i + 1'b1) : rs2_data_i;

        div_by_zero = funct3_i[2] && (rs2_data_i == '0);
        // Only the signed divide/remainder can overflow (funct3[0] clear).
        div_ovf     = funct3_i[2] && !funct3_i[0] &&
                      (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
        special     = div_by_zero | div_ovf;

        // funct3[1] distinguishes remainder from quotient.
        if (div_by_zero) begin
            special_res = funct3_i[1] ? rs1_data_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : rs1_data_i;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of each engine
    // ------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;
    logic [W:0]     div_shift;
    logic           div_ok;
    logic [W-1:0]   div_rem_sub;
    logic [2*W-1:0] div_step;

    always_comb begin
        // Add the multiplicand when the current multiplier LSB is set, then shift
        // the whole accumulator right; the carry lands in the top bit.
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_step = {mul_sum, acc_q[W-1:1]};

        // Bring the next dividend bit into the remainder and try the subtraction.
        // When it succeeds the true difference is below the divisor, so W bits suffice.
        div_shift   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ok      = (div_shift >= {1'b0, opb_q});
        div_rem_sub = div_shift[W-1:0] - opb_q;
        div_step    = div_ok ? {div_rem_sub,       acc_q[W-2:0], 1'b1}
                             : {div_shift[W-1:0],  acc_q[W-2:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Sign correction and result select (FIXUP)
    // ------------------------------------------------------------------
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fixed_res;

    always_comb begin
        prod_fix = neg_q     ? (~acc_q + 1'b1)               : acc_q;
        quo_fix  = neg_q     ? (~acc_q[W-1:0] + 1'b1)        : acc_q[W-1:0];
        rem_fix  = rem_neg_q ? (~acc_q[2*W-1:W] + 1'b1)      : acc_q[2*W-1:W];

        case (op_q)
            3'b000:                 fixed_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fixed_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:         fixed_res = quo_fix;
            default:                fixed_res = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = special ? S_DONE : S_CALC;
                S_CALC:  if (cnt_q == '0) state_d = S_FIXUP;
                S_FIXUP: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;   // start_i deliberately ignored here
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_IDLE:  stall_o = accept;
            S_CALC,
            S_FIXUP: begin
                stall_o = 1'b1;
                busy_o  = 1'b1;
            end
            S_DONE:  done_o = 1'b1;   // stall dropped so the instruction retires now
            default: ;
        endcase
    end

    assign result_o = result_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = funct3_i;
                    cnt_d     = CNT_LOAD;
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    if (funct3_i[2]) begin
                        acc_d = {{W{1'b0}}, abs_a};
                        opb_d = abs_b;
                    end else begin
                        acc_d = {{W{1'b0}}, abs_b};
                        opb_d = abs_a;
                    end
                    if (special) begin
                        result_d = special_res;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_step : mul_step;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_FIXUP: begin
                // An abort in the last cycle must leave the previous result visible.
                if (!flush_i) begin
                    result_d = fixed_res;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Testbench for mul_div_sequencer: directed RV32M vectors with hand-computed results.
// Expected results and done cycles are queued at issue; a monitor compares on every done_o.
// Stall/busy timing, flush abort and asynchronous reset are checked inline.
module tb_mul_div_sequencer;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;
    localparam int         LAT    = 34;
    localparam int         LAT_SP = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    mul_div_sequencer #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .funct3_i  (funct3_i),
        .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];
    string       exp_tag_q[$];

    logic [31:0] last_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && done_o === 1'b1) begin
            if (exp_res_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1 with result %h, expected no done (cycle %0d)",
                         result_o, cyc);
            end else begin
                logic [31:0] r;
                int          c;
                string       t;
                r = exp_res_q.pop_front();
                c = exp_cyc_q.pop_front();
                t = exp_tag_q.pop_front();
                chk({t, "_result"}, result_o, r);
                chk({t, "_done_cycle"}, 32'(cyc), 32'(c));
            end
        end
    end

    // Issue one operation in the current IDLE cycle (caller is #1 after a rising edge).
    // hold keeps start_i asserted through DONE.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit hold);
        int stall_cnt = 0;
        int busy_cnt  = 0;
        bit seen      = 1'b0;
        bit first     = 1'b1;
        start_i    = 1'b1;
        funct3_i   = f;
        rs1_data_i = a;
        rs2_data_i = b;
        exp_res_q.push_back(exp);
        exp_cyc_q.push_back(cyc + lat);
        exp_tag_q.push_back(tag);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (first) begin
                chk({tag, "_busy_c0"}, {31'd0, busy_o}, 32'd0);
                first = 1'b0;
            end
            if (done_o) begin
                seen = 1'b1;
                chk({tag, "_stall_in_done"}, {31'd0, stall_o}, 32'd0);
                chk({tag, "_busy_in_done"}, {31'd0, busy_o}, 32'd0);
            end else begin
                if (stall_o) stall_cnt++;
                if (busy_o)  busy_cnt++;
            end
            @(posedge clk);
            #1;
            if (!hold) start_i = 1'b0;
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
        chk({tag, "_result_hold"}, result_o, exp);
        last_res = exp;
        start_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        funct3_i   = 3'b000;
        rs1_data_i = '0;
        rs2_data_i = '0;
        last_res   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall",  {31'd0, stall_o}, 32'd0);
        chk("reset_busy",   {31'd0, busy_o},  32'd0);
        chk("reset_done",   {31'd0, done_o},  32'd0);
        chk("reset_result", result_o, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Multiply family
        run_op("mul_7x-3",     MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, 1'b0);
        run_op("mul_small",    MUL,    32'h0001_2345, 32'h0000_0100, 32'h0123_4500, LAT, 1'b0);
        run_op("mulhu_max",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 1'b0);
        run_op("mulh_min",     MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, 1'b0);
        run_op("mulhsu_-1x2",  MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, LAT, 1'b0);

        // Divide family
        run_op("div_-7/2",     DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, LAT, 1'b0);
        run_op("rem_-7/2",     REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, LAT, 1'b0);
        run_op("div_7/-2",     DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT, 1'b0);
        run_op("rem_7/-2",     REM,    32'd7,        32'hFFFF_FFFE, 32'd1,        LAT, 1'b0);
        run_op("divu_100/7",   DIVU,   32'd100,      32'd7,        32'd14,       LAT, 1'b0);
        run_op("remu_100/7",   REMU,   32'd100,      32'd7,        32'd2,        LAT, 1'b0);
        run_op("divu_max/1",   DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, LAT, 1'b0);

        // Special cases: decided in IDLE, done in cycle 1
        run_op("divu_by0",     DIVU,   32'h0000_1234, 32'd0,        32'hFFFF_FFFF, LAT_SP, 1'b0);
        run_op("rem_by0",      REM,    32'h0000_1234, 32'd0,        32'h0000_1234, LAT_SP, 1'b0);
        run_op("div_ovf",      DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP, 1'b0);
        run_op("rem_ovf",      REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        LAT_SP, 1'b0);

        // Flush mid-divide in cycle 10: no done, result unchanged
        start_i    = 1'b1;
        funct3_i   = DIV;
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", {31'd0, busy_o}, 32'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_stall_after",  {31'd0, stall_o}, 32'd0);
        chk("flush_busy_after",   {31'd0, busy_o},  32'd0);
        chk("flush_done_after",   {31'd0, done_o},  32'd0);
        chk("flush_result_after", result_o, last_res);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_result_later", result_o, last_res);

        // Asynchronous reset between edges in the middle of CALC
        start_i    = 1'b1;
        funct3_i   = MUL;
        rs1_data_i = 32'd123;
        rs2_data_i = 32'd456;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("areset_busy_before", {31'd0, busy_o}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_stall",  {31'd0, stall_o}, 32'd0);
        chk("areset_busy",   {31'd0, busy_o},  32'd0);
        chk("areset_done",   {31'd0, done_o},  32'd0);
        chk("areset_result", result_o, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        last_res = '0;
        @(posedge clk);
        #1;

        // start_i held through DONE: no restart; the next op is taken in the following IDLE cycle
        run_op("hold_divu_by0", DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF, LAT_SP, 1'b1);
        run_op("b2b_remu",      REMU, 32'd100, 32'd7, 32'd2,         LAT,    1'b1);
        run_op("b2b_mul",       MUL,  32'd6,   32'd7, 32'd42,        LAT,    1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
Iterative multi-cycle controller for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU and is started by the control unit when an M-extension R-type instruction is decoded (funct7 = 0000001). It sequences a shift-add multiplier or restoring divider one bit per clock. It stalls the core's PC and register-file write until the result is ready.

Parameters:
DATA_WIDTH, 32, operand/result width W; legal range 2 and up.
CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE
start_i  input  1  M-extension instruction present in decode
funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data_i  input  W  operand A (multiplicand/dividend)
rs2_data_i  input  W  operand B (multiplier/divisor)
flush_i  input  1  synchronous abort
stall_o  output  1  hold PC and suppress register write
busy_o  output  1  unit occupied (CALC or FIXUP)
done_o  output  1  result valid, one-cycle pulse
result_o  output  W  registered result

Behaviour:
- Reset (async, any state): state=IDLE; counter, accumulators and result_o = 0; stall_o, busy_o and done_o = 0.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - When start_i=1 and flush_i=0, latch funct3_i, take absolute values of the operands (signed ops only), record result sign, and load counter = W-1.
  - Next state is CALC, or DONE for special cases.
- Operand signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: either interpretation (low W bits are identical).
  - DIV, REM: both signed.
- Special cases (decided in IDLE, no CALC):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give rs1.
  - Signed overflow (rs1 = -2^(W-1), rs2 = -1): DIV gives rs1; REM gives 0.
  - Path: IDLE -> DONE; result_o loaded on the same edge.
- CALC: one iteration per cycle, W cycles total; transition to FIXUP when counter = 0, otherwise decrement.
  - Multiply: 2W-bit shift-add of the magnitudes.
  - Divide: restoring subtract/shift giving a W-bit quotient and W-bit remainder.
- FIXUP (1 cycle): apply sign correction, then select and register result_o; next state DONE.
  - Negate the product if the result sign is negative.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder takes the sign of the dividend.
  - Result select: MUL = product[W-1:0]; MULH/MULHSU/MULHU = product[2W-1:W]; DIV/DIVU = quotient; REM/REMU = remainder.
- DONE (1 cycle): done_o=1; start_i ignored, because the same instruction retires this cycle. Next state IDLE.
- Latency:
  - start_i sampled in cycle 0 -> done_o in cycle W+2 (34 for W=32).
  - Special case: done_o in cycle 1.
- stall_o (combinational) = (IDLE and start_i and not flush_i) or CALC or FIXUP. It is low in DONE so the instruction retires with result_o.
- busy_o = CALC or FIXUP.
- result_o holds its value from the DONE cycle until the next result load; it is never cleared except by reset.
- flush_i=1: next state IDLE from any state. It has priority over start_i in the same cycle; result_o is unchanged and no done_o is produced for the aborted operation.
- Widths: all internal arithmetic is unsigned on magnitudes. Negation is two's complement at W (operands, quotient, remainder) or 2W (product). No overflow flag is produced.
- Back-to-back operations: the earliest next acceptance is the IDLE cycle following DONE.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> stall_o high in cycles 0..33; done_o=1 in cycle 34 only; result_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF (-1) x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF with done_o in cycle 1. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Start a DIV, then assert flush_i in cycle 10 -> IDLE next cycle; stall_o and busy_o low; no done_o; result_o keeps its prior value.
- Assert reset asynchronously mid-CALC (between edges) -> all outputs 0 immediately. Holding start_i high through DONE -> no restart; a new operation is accepted only in the following IDLE cycle.
